// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg
//   Shared types and helpers for spi_tx_arbiter and its round-robin picker.
//   state_t    : arbiter FSM states
//   cnt_width(): width of the shared gap/start-timeout counter
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4
  } state_t;

  // One counter serves both the start timeout (counts up to START_TIMEOUT)
  // and the inter-frame gap (counts up to GAP_CYCLES-1), so size it for the
  // larger of the two terminal values.
  function automatic int cnt_width(input int timeout_cycles, input int gap_cycles);
    int max_v;
    max_v = (timeout_cycles > gap_cycles) ? timeout_cycles : gap_cycles;
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
//   Combinational round-robin search: returns the first asserted request
//   found when scanning i_ptr, i_ptr+1, ... (mod NUM_REQ).
//   i_req   [NUM_REQ]  request vector
//   i_ptr   [PTR_W]    index with highest priority this cycle
//   o_idx   [PTR_W]    selected index (valid when o_found)
//   o_found [1]        at least one request asserted
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_found
);

  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [PTR_W-1:0]     w_off;
  logic [PTR_W:0]       w_sum;

  // Rotating the doubled vector puts i_ptr at bit 0, so a plain
  // lowest-set-bit search yields the offset from the pointer.
  assign w_req_dbl = {i_req, i_req};
  assign w_req_rot = NUM_REQ'(w_req_dbl >> i_ptr);

  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        o_found = 1'b1;
        w_off   = PTR_W'(k);
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= NUM_REQ_W) ? PTR_W'(w_sum - NUM_REQ_W) : w_sum[PTR_W-1:0];

endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
//   Shares one spi_gen transmitter between NUM_REQ requesters with a
//   round-robin grant, launches spi_gen with a one-cycle trigger, follows
//   the frame through spi_gen's sel_out and enforces an inter-frame gap.
//   clk_in          system clock
//   rst_in          synchronous active-low reset
//   req_valid_in    per-requester message valid
//   req_data_in     requester i message at [i*MESSAGE_WIDTH +: MESSAGE_WIDTH]
//   req_ready_out   one-hot, one-cycle accept pulse
//   spi_msg_out     message to spi_gen, held until the next accept
//   spi_trigger_out one-cycle launch pulse to spi_gen
//   spi_sel_in      spi_gen sel_out, low while a frame is on the wire
//   grant_id_out    requester of the current/last frame
//   busy_out        high whenever the FSM is not IDLE
//   done_out        one-cycle pulse when sel returns high
//   err_out         one-cycle pulse when sel never went low after a trigger
module spi_tx_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MESSAGE_WIDTH = 16,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  input  logic [NUM_REQ*MESSAGE_WIDTH-1:0]   req_data_in,
  output logic [NUM_REQ-1:0]                 req_ready_out,
  output logic [MESSAGE_WIDTH-1:0]           spi_msg_out,
  output logic                               spi_trigger_out,
  input  logic                               spi_sel_in,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id_out,
  output logic                               busy_out,
  output logic                               done_out,
  output logic                               err_out
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(START_TIMEOUT, GAP_CYCLES);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST      = ID_W'(NUM_REQ - 1);

  state_t                   r_state, w_state_next;
  logic [CNT_W-1:0]         r_cnt, w_cnt_next;
  logic [ID_W-1:0]          r_ptr, w_ptr_next;
  logic [ID_W-1:0]          r_grant_id, w_grant_id_next;
  logic [MESSAGE_WIDTH-1:0] r_msg, w_msg_next;
  logic [ID_W-1:0]          w_pick_idx;
  logic                     w_pick_found;
  logic                     w_accept;
  logic [MESSAGE_WIDTH-1:0] w_req_data [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_req_data[gi]    = req_data_in[gi*MESSAGE_WIDTH +: MESSAGE_WIDTH];
      assign req_ready_out[gi] = w_accept && (w_pick_idx == ID_W'(gi));
    end
  endgenerate

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_picker (
    .i_req   (req_valid_in),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_msg      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_ptr      <= w_ptr_next;
      r_grant_id <= w_grant_id_next;
      r_msg      <= w_msg_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_ptr_next      = r_ptr;
    w_grant_id_next = r_grant_id;
    w_msg_next      = r_msg;
    w_accept        = 1'b0;
    spi_trigger_out = 1'b0;
    done_out        = 1'b0;
    err_out         = 1'b0;
    case (r_state)
      IDLE: begin
        // Ready is suppressed while reset is held so no requester sees a
        // handshake that the reset is about to discard.
        if (w_pick_found && rst_in) begin
          w_accept        = 1'b1;
          w_msg_next      = w_req_data[w_pick_idx];
          w_grant_id_next = w_pick_idx;
          w_ptr_next      = (w_pick_idx == ID_LAST) ? '0 : w_pick_idx + 1'b1;
          w_state_next    = LAUNCH;
        end
      end
      LAUNCH: begin
        spi_trigger_out = 1'b1;
        w_cnt_next      = '0;
        w_state_next    = WAIT_START;
      end
      WAIT_START: begin
        // sel low wins over the timeout on the terminal cycle.
        if (!spi_sel_in) begin
          w_state_next = WAIT_DONE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          err_out      = 1'b1;
          w_cnt_next   = '0;
          w_state_next = GAP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (spi_sel_in) begin
          done_out     = 1'b1;
          w_cnt_next   = '0;
          w_state_next = GAP;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign spi_msg_out  = r_msg;
  assign grant_id_out = r_grant_id;
  assign busy_out     = (r_state != IDLE);

endmodule
